// File: rtl/mac_operand_feeder.sv
// Operand feeder for the 4x4 MAC: buffers (A,B) pairs, issues them one at a time,
// waits for done, and hands the captured result downstream on valid/ready.
//   state  | meaning
//   IDLE   | waiting for a buffered pair; pops head into mac_a/mac_b
//   ISSUE  | mac_go pulse, watchdog loaded
//   WAIT   | waiting for a rising mac_done; watchdog counts down
//   OUTPUT | result held until res_ready
module mac_operand_feeder #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int DW      = 4,
    parameter int RW      = 12,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    output logic [DW-1:0] mac_a,
    output logic [DW-1:0] mac_b,
    output logic          mac_go,
    input  logic [RW-1:0] mac_out,
    input  logic          mac_done,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [RW-1:0] res_data,
    output logic [AW:0]   level,
    output logic          busy,
    output logic          err
);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);
    localparam logic [WDW-1:0] WD_LOAD = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_OUTPUT
    } state_t;

    state_t state, state_nxt;

    logic [2*DW-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [WDW-1:0]  wd_cnt;
    logic            done_q;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            capture;
    logic            timeout;
    logic            wd_load;

    assign full     = (level == FULL_LEVEL);
    assign empty    = (level == '0);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        wd_load   = 1'b0;
        mac_go    = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mac_go    = 1'b1;
                wd_load   = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // edge detect so a done level left from the previous op is not taken as completion
                if (mac_done && !done_q) begin
                    capture   = 1'b1;
                    state_nxt = S_OUTPUT;
                end else if (wd_cnt == '0) begin
                    timeout   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_OUTPUT: begin
                if (res_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // storage has no reset; emptiness is carried by the pointers and level
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_a, in_b};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            mac_a     <= '0;
            mac_b     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            err       <= 1'b0;
            done_q    <= 1'b0;
            wd_cnt    <= '0;
        end else begin
            state  <= state_nxt;
            done_q <= mac_done;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr         <= rd_ptr + 1'b1;
                {mac_a, mac_b} <= mem[rd_ptr];
            end
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
            // watchdog: down-counter, terminal count at zero ends the WAIT
            if (wd_load)                             wd_cnt <= WD_LOAD;
            else if (state == S_WAIT && wd_cnt != '0) wd_cnt <= wd_cnt - 1'b1;
            if (capture) begin
                res_data  <= mac_out;
                res_valid <= 1'b1;
            end else if (state == S_OUTPUT && res_ready) begin
                res_valid <= 1'b0;
            end
            if (timeout) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder: MAC responder model plus a result scoreboard
// filled from accepted pushes and drained on each result handshake.
module tb_mac_operand_feeder;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int DW    = 4;
    localparam int RW    = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic [DW-1:0] mac_a;
    logic [DW-1:0] mac_b;
    logic          mac_go;
    logic [RW-1:0] mac_out = '0;
    logic          mac_done = 1'b0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [RW-1:0] res_data;
    logic [AW:0]   level;
    logic          busy;
    logic          err;

    mac_operand_feeder #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .RW(RW), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .mac_a(mac_a), .mac_b(mac_b), .mac_go(mac_go),
        .mac_out(mac_out), .mac_done(mac_done), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .level(level), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int go_cnt = 0;
    int nres  = 0;
    bit sb_en = 1'b0;
    logic [RW-1:0] sbq[$];

    int mac_lat   = 4;
    bit mac_lvl   = 1'b0;
    bit mac_stall = 1'b0;
    int mk = -1;
    logic [RW-1:0] mac_pend;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // MAC responder: done rises mac_lat negedges after go; pulse or held-level mode
    always @(negedge clk) begin
        if (rst) begin
            mk = -1;
            mac_done = 1'b0;
            mac_out = '0;
        end else if (mac_go) begin
            mk = 0;
            mac_pend = mac_a * mac_b;
            if (!mac_lvl) mac_done = 1'b0;
        end else if (mk >= 0) begin
            mk++;
            if (mac_lvl && mk == 2) mac_done = 1'b0;
            if (!mac_stall && mk == mac_lat) begin
                mac_done = 1'b1;
                mac_out = mac_pend;
                if (mac_lvl) mk = -1;
            end else if (!mac_lvl && mk == mac_lat + 1) begin
                mac_done = 1'b0;
                mk = -1;
            end
        end
    end

    always @(posedge clk) if (mac_go) go_cnt++;

    always begin
        @(negedge clk);
        #1;
        if (!rst && res_valid && res_ready) begin
            check("sb_pending", sbq.size() != 0, 1);
            if (sbq.size() != 0) check("sb_result", res_data, sbq.pop_front());
            nres++;
        end
    end

    task automatic push_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
        bit acc = 1'b0;
        int n = 0;
        logic [RW-1:0] p;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        while (!acc && n < 2000) begin
            acc = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        check("push_accepted", acc, 1);
        p = a * b;
        if (acc && sb_en) sbq.push_back(p);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sbq.size() != 0 || busy || level != 0) && n < 3000) begin
            tick();
            n++;
        end
        check({tag, "_drain_in_time"}, n < 3000, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        res_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        sbq.delete();
    endtask

    initial begin
        int g, g0, n0, w;
        logic [DW-1:0] la [4];
        logic [DW-1:0] lb [4];

        // reset values
        do_reset();
        check("rst_in_ready", in_ready, 1);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_mac_go", mac_go, 0);
        check("rst_mac_ab", {mac_a, mac_b}, 0);

        // single pair, 4-cycle MAC pulse
        mac_lat = 4; mac_lvl = 0; mac_stall = 0; sb_en = 1;
        n0 = nres; g0 = go_cnt;
        push_pair(4'd3, 4'd5);
        check("single_level", level, 1);
        check("single_go_early", mac_go, 0);
        tick();
        check("single_go", mac_go, 1);
        check("single_mac_a", mac_a, 3);
        check("single_mac_b", mac_b, 5);
        check("single_busy", busy, 1);
        check("single_popped", level, 0);
        tick();
        check("single_go_once", mac_go, 0);
        tick(); tick(); tick();
        check("single_valid_early", res_valid, 0);
        tick();
        check("single_valid", res_valid, 1);
        check("single_data", res_data, 15);
        tick();
        check("single_hold_valid", res_valid, 1);
        check("single_hold_data", res_data, 15);
        res_ready = 1'b1;
        tick();
        check("single_valid_clr", res_valid, 0);
        check("single_idle", busy, 0);
        check("single_nres", nres - n0, 1);
        check("single_ngo", go_cnt - g0, 1);

        // fill/full with stalled MAC, then watchdog timeout and reset in WAIT
        do_reset();
        mac_stall = 1; sb_en = 0; res_ready = 1'b1;
        g = -1; g0 = go_cnt;
        for (int i = 1; i <= 9; i++) begin
            push_pair(4'(i), 4'(i));
            if (mac_go) g = cyc;
        end
        check("fill_level", level, 8);
        check("fill_in_ready", in_ready, 0);
        check("fill_head_a", mac_a, 1);
        in_valid = 1'b1; in_a = 4'd10; in_b = 4'd10;
        tick();
        in_valid = 1'b0;
        check("full_push_ignored", level, 8);
        check("fill_ngo", go_cnt - g0, 1);
        w = 0;
        while (cyc < g + 255 && w < 400) begin
            tick();
            w++;
        end
        check("to_err_early", err, 0);
        check("to_busy_wait", busy, 1);
        tick();
        check("to_err", err, 1);
        check("to_idle", busy, 0);
        check("to_level", level, 8);
        tick();
        check("to_next_go", mac_go, 1);
        check("to_next_a", mac_a, 2);
        check("to_next_b", mac_b, 2);
        check("to_next_level", level, 7);
        check("to_err_sticky", err, 1);
        tick();
        rst = 1'b1;
        tick();
        check("rstwait_level", level, 0);
        check("rstwait_busy", busy, 0);
        check("rstwait_go", mac_go, 0);
        check("rstwait_err", err, 0);
        check("rstwait_in_ready", in_ready, 1);

        // stream of 20 pairs through the FIFO (pointers wrap twice)
        do_reset();
        mac_stall = 0; mac_lvl = 0; mac_lat = 3; sb_en = 1; res_ready = 1'b1;
        n0 = nres;
        for (int i = 0; i < 20; i++) push_pair(4'(i), 4'(15 - i));
        drain("stream");
        check("stream_nres", nres - n0, 20);
        check("stream_err", err, 0);

        // level-held done from the MAC
        do_reset();
        mac_lvl = 1; mac_lat = 4; res_ready = 1'b1;
        la[0] = 4'd7;  lb[0] = 4'd9;
        la[1] = 4'd15; lb[1] = 4'd15;
        la[2] = 4'd2;  lb[2] = 4'd13;
        la[3] = 4'd0;  lb[3] = 4'd6;
        n0 = nres; g0 = go_cnt;
        for (int i = 0; i < 4; i++) push_pair(la[i], lb[i]);
        drain("lvl");
        check("lvl_nres", nres - n0, 4);
        check("lvl_ngo", go_cnt - g0, 4);

        // result backpressure
        do_reset();
        mac_lvl = 0; mac_lat = 3; res_ready = 1'b0;
        n0 = nres;
        push_pair(4'd5, 4'd6);
        push_pair(4'd7, 4'd8);
        push_pair(4'd9, 4'd10);
        w = 0;
        while (!res_valid && w < 100) begin
            tick();
            w++;
        end
        check("bp_valid_seen", res_valid, 1);
        g0 = go_cnt;
        for (int k = 0; k < 10; k++) begin
            if (k < 2) push_pair(4'(k + 1), 4'd2);
            else tick();
            check("bp_hold_valid", res_valid, 1);
            check("bp_hold_data", res_data, 30);
        end
        check("bp_no_go", go_cnt - g0, 0);
        check("bp_level", level, 4);
        res_ready = 1'b1;
        drain("bp");
        check("bp_nres", nres - n0, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
